// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI definitions. Holds the transmitter state
//               enumeration, default word width and clock divider (also used
//               by the spi_rx benches), and a small helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_WIDTH_DEFAULT   = 24;
    localparam int SPI_CLK_DIV_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4
    } spi_tx_state_t;

    // Largest of three timing parameters; sizes the shared timing counter.
    function automatic int spi_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx
// Description : SPI master transmitter. Accepts a WIDTH-bit word on a
//               ready/start handshake, drops chip-select, generates SCLK
//               (idle low) from clock_i and shifts the word out MSB-first.
//               MOSI changes on SCLK rising edges so it is stable at each
//               falling edge, where the peripheral samples it.
// Ports       : clock_i     - system clock
//               reset_i     - asynchronous, active-low reset
//               tx_start_i  - transfer request, honoured only while ready
//               tx_data_i   - word to send, sampled at acceptance
//               tx_ready_o  - idle, able to accept a start
//               tx_done_o   - one-cycle pulse when CS has been released
//               SCLK_o      - SPI clock
//               MOSI_o      - serial data out, MSB first
//               CS_n_o      - active-low chip select
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx
    import spi_pkg::*;
#(
    parameter int WIDTH    = SPI_WIDTH_DEFAULT,
    parameter int CLK_DIV  = SPI_CLK_DIV_DEFAULT,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             tx_start_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic             tx_ready_o,
    output logic             tx_done_o,
    output logic             SCLK_o,
    output logic             MOSI_o,
    output logic             CS_n_o
);

    localparam int c_CNT_W = $clog2(spi_max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
    localparam int c_BIT_W = $clog2(WIDTH + 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
    localparam logic [c_BIT_W-1:0] c_BITS_ALL   = c_BIT_W'(WIDTH);

    localparam logic [2:0] c_ST_IDLE     = IDLE;
    localparam logic [2:0] c_ST_SETUP    = SETUP;
    localparam logic [2:0] c_ST_SHIFT_HI = SHIFT_HI;
    localparam logic [2:0] c_ST_SHIFT_LO = SHIFT_LO;
    localparam logic [2:0] c_ST_HOLD     = HOLD;

    generate
        if (WIDTH < 1 || CLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1) begin : g_param_check
            $error("spi_tx: WIDTH, CLK_DIV, CS_SETUP and CS_HOLD must all be >= 1");
        end
    endgenerate

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_tcnt;
    logic [c_BIT_W-1:0] r_bits;
    logic [WIDTH-1:0]   r_shift;
    logic               r_ready;
    logic               r_done;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_csn;
    logic               w_tlast;

    // Last cycle of the current timed phase.
    always_comb begin
        w_tlast = 1'b0;
        case (r_state)
            c_ST_SETUP:    w_tlast = (r_tcnt == c_SETUP_LAST);
            c_ST_SHIFT_HI: w_tlast = (r_tcnt == c_HALF_LAST);
            c_ST_SHIFT_LO: w_tlast = (r_tcnt == c_HALF_LAST);
            c_ST_HOLD:     w_tlast = (r_tcnt == c_HOLD_LAST);
            default:       w_tlast = 1'b0;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= c_ST_IDLE;
            r_tcnt  <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_csn   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (tx_start_i && r_ready) begin
                        r_shift <= tx_data_i;
                        r_csn   <= 1'b0;
                        r_ready <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (w_tlast) begin
                        // First rising edge carries the MSB onto MOSI.
                        r_sclk  <= 1'b1;
                        r_mosi  <= r_shift[WIDTH-1];
                        r_shift <= r_shift << 1;
                        r_bits  <= c_BIT_W'(1);
                        r_tcnt  <= '0;
                        r_state <= c_ST_SHIFT_HI;
                    end else begin
                        r_tcnt <= r_tcnt + c_CNT_W'(1);
                    end
                end
                c_ST_SHIFT_HI: begin
                    if (w_tlast) begin
                        r_sclk  <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= c_ST_SHIFT_LO;
                    end else begin
                        r_tcnt <= r_tcnt + c_CNT_W'(1);
                    end
                end
                c_ST_SHIFT_LO: begin
                    if (w_tlast) begin
                        r_tcnt <= '0;
                        if (r_bits != c_BITS_ALL) begin
                            // Next bit changes on the same edge SCLK rises.
                            r_sclk  <= 1'b1;
                            r_mosi  <= r_shift[WIDTH-1];
                            r_shift <= r_shift << 1;
                            r_bits  <= r_bits + c_BIT_W'(1);
                            r_state <= c_ST_SHIFT_HI;
                        end else begin
                            r_state <= c_ST_HOLD;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + c_CNT_W'(1);
                    end
                end
                c_ST_HOLD: begin
                    if (w_tlast) begin
                        r_csn   <= 1'b1;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready_o = r_ready;
    assign tx_done_o  = r_done;
    assign SCLK_o     = r_sclk;
    assign MOSI_o     = r_mosi;
    assign CS_n_o     = r_csn;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_tx
// Description : Self-checking bench for spi_tx. Three instances with
//               different parameter sets share one clock and reset. A
//               passive monitor records SCLK edges and the MOSI bit seen at
//               every SCLK fall; expected words, edge counts and done
//               latencies come from the transfer rules with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_tx;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    logic [2:0]  start;
    logic [7:0]  data_a;
    logic [0:0]  data_b;
    logic [23:0] data_c;
    logic [2:0]  ready, done, sclk, mosi, csn;

    // Instance 0: 8-bit, divider 4, setup/hold 2
    spi_tx #(.WIDTH(8), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u_a (
        .clock_i(clk), .reset_i(reset_i), .tx_start_i(start[0]), .tx_data_i(data_a),
        .tx_ready_o(ready[0]), .tx_done_o(done[0]), .SCLK_o(sclk[0]), .MOSI_o(mosi[0]),
        .CS_n_o(csn[0]));
    // Instance 1: minimal 1-bit transfer, all timings 1
    spi_tx #(.WIDTH(1), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_b (
        .clock_i(clk), .reset_i(reset_i), .tx_start_i(start[1]), .tx_data_i(data_b),
        .tx_ready_o(ready[1]), .tx_done_o(done[1]), .SCLK_o(sclk[1]), .MOSI_o(mosi[1]),
        .CS_n_o(csn[1]));
    // Instance 2: 24-bit, divider 2, asymmetric setup/hold
    spi_tx #(.WIDTH(24), .CLK_DIV(2), .CS_SETUP(3), .CS_HOLD(1)) u_c (
        .clock_i(clk), .reset_i(reset_i), .tx_start_i(start[2]), .tx_data_i(data_c),
        .tx_ready_o(ready[2]), .tx_done_o(done[2]), .SCLK_o(sclk[2]), .MOSI_o(mosi[2]),
        .CS_n_o(csn[2]));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled on the falling clock edge.
    logic [2:0]  prev_sclk = 3'b000;
    logic [2:0]  prev_csn  = 3'b111;
    int          rises[3]    = '{0, 0, 0};
    int          falls[3]    = '{0, 0, 0};
    int          dones[3]    = '{0, 0, 0};
    int          idle_tog[3] = '{0, 0, 0};
    logic [31:0] cap[3]      = '{32'd0, 32'd0, 32'd0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!prev_sclk[i] && sclk[i]) rises[i] <= rises[i] + 1;
            if (prev_sclk[i] && !sclk[i]) begin
                falls[i] <= falls[i] + 1;
                cap[i]   <= {cap[i][30:0], mosi[i]};
            end
            if (prev_csn[i] && csn[i] && (prev_sclk[i] != sclk[i]))
                idle_tog[i] <= idle_tog[i] + 1;
            if (done[i]) dones[i] <= dones[i] + 1;
        end
        prev_sclk <= sclk;
        prev_csn  <= csn;
    end

    // Start-to-done latency derived from the phase lengths.
    function automatic int latency(input int w, input int d, input int s, input int h);
        return 1 + s + 2 * d * w + h;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int i, input int budget, output int at_cyc, output bit ok);
        ok     = 1'b0;
        at_cyc = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done[i]) begin
                at_cyc = cyc;
                ok     = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  k, k2, d1, d2, r0, f0, dn0, hi_len, hi_mosi;
        bit  ok;
        logic [23:0] word;

        reset_i = 1'b0;
        start   = 3'b000;
        data_a  = '0;
        data_b  = '0;
        data_c  = '0;
        repeat (3) @(negedge clk);

        // Reset state of every instance: {sclk,mosi,csn,ready,done}
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_outs_%0d", i), 32'({sclk[i], mosi[i], csn[i], ready[i], done[i]}), 32'b00110);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);

        // ---- A5 with start held high and data scrambled during the transfer
        r0 = rises[0]; f0 = falls[0]; dn0 = dones[0];
        data_a   = 8'hA5;
        start[0] = 1'b1;
        k  = cyc;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (done[0]) begin
                ok = 1'b1;
                d1 = cyc;
                start[0] = 1'b0;
            end else begin
                data_a = 8'($urandom);
            end
        end
        check("a5_done_seen", 32'(ok), 32'd1);
        check("a5_latency", 32'(d1 - k), 32'(latency(8, 4, 2, 2)));
        check("a5_word", cap[0][7:0], 32'hA5);
        check("a5_rises", 32'(rises[0] - r0), 32'd8);
        check("a5_falls", 32'(falls[0] - f0), 32'd8);
        repeat (4) @(negedge clk);
        check("a5_single_done", 32'(dones[0] - dn0), 32'd1);
        check("a5_idle_after", 32'({ready[0], csn[0], sclk[0]}), 32'b110);

        // ---- Random 24-bit words on instance 2, data changed after acceptance
        for (int t = 0; t < 3; t++) begin
            word = 24'($urandom);
            r0 = rises[2];
            data_c   = word;
            start[2] = 1'b1;
            k = cyc;
            @(negedge clk);
            start[2] = 1'b0;
            data_c   = ~word;
            wait_done(2, 300, d1, ok);
            check($sformatf("c%0d_done_seen", t), 32'(ok), 32'd1);
            check($sformatf("c%0d_latency", t), 32'(d1 - k), 32'(latency(24, 2, 3, 1)));
            check($sformatf("c%0d_word", t), cap[2][23:0], 32'(word));
            check($sformatf("c%0d_rises", t), 32'(rises[2] - r0), 32'd24);
            @(negedge clk);
        end

        // ---- Minimal 1-bit transfer: SCLK high for one cycle (period 2)
        r0 = rises[1];
        data_b   = 1'b1;
        start[1] = 1'b1;
        k = cyc;
        @(negedge clk);
        start[1] = 1'b0;
        hi_len  = 0;
        hi_mosi = 0;
        ok = 1'b0;
        if (sclk[1]) begin hi_len++; if (mosi[1]) hi_mosi++; end
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (sclk[1]) begin hi_len++; if (mosi[1]) hi_mosi++; end
            if (done[1]) begin ok = 1'b1; d1 = cyc; end
        end
        check("b_done_seen", 32'(ok), 32'd1);
        check("b_latency", 32'(d1 - k), 32'(latency(1, 1, 1, 1)));
        check("b_sclk_high_len", 32'(hi_len), 32'd1);
        check("b_mosi_while_high", 32'(hi_mosi), 32'd1);
        check("b_rises", 32'(rises[1] - r0), 32'd1);
        check("b_word", cap[1][0:0], 32'd1);

        // ---- Reset in the high half of the third bit
        data_a   = 8'hFF;
        start[0] = 1'b1;
        k = cyc;
        @(negedge clk);
        start[0] = 1'b0;
        // third rise at k+1+2+2*4*2 = k+19; its high half spans k+19..k+22
        while (cyc < k + 20) @(negedge clk);
        check("rst_pre_state", 32'({sclk[0], mosi[0], csn[0]}), 32'b110);
        #2 reset_i = 1'b0;
        #1 check("rst_async_outs", 32'({csn[0], sclk[0], mosi[0]}), 32'b100);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_ready_after", 32'(ready[0]), 32'd1);

        r0 = rises[0];
        data_a   = 8'h3C;
        start[0] = 1'b1;
        k = cyc;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 200, d1, ok);
        check("3c_done_seen", 32'(ok), 32'd1);
        check("3c_latency", 32'(d1 - k), 32'(latency(8, 4, 2, 2)));
        check("3c_word", cap[0][7:0], 32'h3C);
        check("3c_rises", 32'(rises[0] - r0), 32'd8);
        repeat (2) @(negedge clk);

        // ---- Back-to-back: start held through the done cycle
        r0 = rises[0];
        data_a   = 8'h01;
        start[0] = 1'b1;
        k = cyc;
        wait_done(0, 200, d1, ok);
        check("b2b_first_done", 32'(ok), 32'd1);
        check("b2b_cs_high_at_done", 32'(csn[0]), 32'd1);
        data_a = 8'h80;
        @(negedge clk);
        start[0] = 1'b0;
        k2 = d1;
        check("b2b_cs_low_next", 32'(csn[0]), 32'd0);
        wait_done(0, 200, d2, ok);
        check("b2b_second_done", 32'(ok), 32'd1);
        check("b2b_lat1", 32'(d1 - k), 32'(latency(8, 4, 2, 2)));
        check("b2b_lat2", 32'(d2 - k2), 32'(latency(8, 4, 2, 2)));
        check("b2b_words", cap[0][15:0], 32'h0180);
        check("b2b_rises", 32'(rises[0] - r0), 32'd16);
        repeat (2) @(negedge clk);

        check("idle_toggles", 32'(idle_tog[0] + idle_tog[1] + idle_tog[2]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
